// File: rtl/dsp48a1_mac_seq.sv
// Sequencer for a free-running DSP48A1 slice used as an unsigned dot-product
// engine. Operand beats go onto slice A/B. A tag for each beat travels
// alongside the slice pipeline and steers OPMODE and C at the right cycle.
// The final P and the OR of CARRYOUT for each vector go into a 2-entry
// result FIFO.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. IN_READY and RES_VALID depend only on registered state, never on
// IN_VALID or RES_READY.
module dsp48a1_mac_seq #(
    parameter int AB_LAT = 1,
    parameter int M_LAT  = 1,
    parameter int OP_LAT = 1,
    parameter int C_LAT  = 1,
    parameter int P_LAT  = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    input  logic        IN_FIRST,
    input  logic        IN_LAST,
    input  logic [47:0] IN_BIAS,
    input  logic        IN_SUB,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [17:0] DSP_D,
    output logic [47:0] DSP_C,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CE,
    output logic        DSP_CARRYIN,
    output logic        DSP_RST,
    input  logic [47:0] DSP_P,
    input  logic        DSP_CARRYOUT,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic [47:0] RES_DATA,
    output logic        RES_CARRY
);

    // Stage index of a beat's adder cycle, and of the cycle when P shows it.
    localparam int D   = AB_LAT + M_LAT;
    localparam int TL  = D + P_LAT;
    localparam int OPI = D - OP_LAT;
    localparam int CI  = D - C_LAT;

    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic        sub;
        logic [47:0] bias;
    } tag_t;

    tag_t        tag_q [0:TL];
    logic [17:0] a_q;
    logic [17:0] b_q;
    logic [7:0]  op_prev;
    logic [47:0] c_hold;
    logic        flag_q;
    logic        carry_next;
    logic        accept;
    logic        push;
    logic        pop;
    logic [1:0]  pending;
    logic [1:0]  fifo_cnt;
    logic [48:0] fifo_q [0:1];
    logic [48:0] push_data;
    logic [1:0]  bubble_z;

    assign accept      = IN_VALID & IN_READY;
    assign IN_READY    = (pending < 2'd2);
    assign DSP_A       = a_q;
    assign DSP_B       = b_q;
    assign DSP_D       = 18'd0;
    assign DSP_CE      = 1'b1;
    assign DSP_CARRYIN = 1'b0;
    assign DSP_RST     = RST;

    // Stage 0: register accepted operands onto the slice; bubbles drive zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= 18'd0;
            b_q <= 18'd0;
        end else begin
            a_q <= accept ? IN_A : 18'd0;
            b_q <= accept ? IN_B : 18'd0;
        end
    end

    // Tag pipeline that tracks each beat through the slice stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k <= TL; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0].valid <= accept;
            tag_q[0].first <= accept & IN_FIRST;
            tag_q[0].last  <= accept & IN_LAST;
            tag_q[0].sub   <= IN_SUB;
            tag_q[0].bias  <= IN_BIAS;
            for (int k = 1; k <= TL; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // OPMODE: X=M with Z=C on first beats and Z=P otherwise. A bubble clears
    // X. A bubble also turns Z=C into Z=P, so a bubble right after a first
    // beat cannot reload the bias over the running sum. From reset the
    // opmode stays 0 until the first beat.
    always_comb begin
        bubble_z = (op_prev[3:2] == 2'b11) ? 2'b10 : op_prev[3:2];
        DSP_OPMODE = {op_prev[7], 3'b000, bubble_z, 2'b00};
        if (tag_q[OPI].valid) begin
            DSP_OPMODE = {tag_q[OPI].sub, 3'b000,
                          (tag_q[OPI].first ? 2'b11 : 2'b10), 2'b01};
        end
    end

    // C carries the bias of a first beat at its launch cycle and holds otherwise.
    always_comb begin
        DSP_C = c_hold;
        if (tag_q[CI].valid && tag_q[CI].first) DSP_C = tag_q[CI].bias;
    end

    // Remember the last driven OPMODE and C so bubbles can hold them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_prev <= 8'd0;
            c_hold  <= 48'd0;
        end else begin
            op_prev <= DSP_OPMODE;
            c_hold  <= DSP_C;
        end
    end

    // Collector: fold CARRYOUT into the vector's flag; a last beat emits a result.
    always_comb begin
        carry_next = tag_q[TL].first ? DSP_CARRYOUT : (flag_q | DSP_CARRYOUT);
        push       = tag_q[TL].valid & tag_q[TL].last;
        push_data  = {DSP_P, carry_next};
    end

    // Carry flag register, updated only by real beats.
    always_ff @(posedge CLK) begin
        if (RST) flag_q <= 1'b0;
        else if (tag_q[TL].valid) flag_q <= carry_next;
    end

    assign RES_VALID = (fifo_cnt != 2'd0);
    assign RES_DATA  = fifo_q[0][48:1];
    assign RES_CARRY = fifo_q[0][0];
    assign pop       = RES_VALID & RES_READY;

    // 2-entry result FIFO. Entry 0 is the head and stays put while stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fifo_cnt  <= 2'd0;
            fifo_q[0] <= 49'd0;
            fifo_q[1] <= 49'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo_q[0] <= push_data;
                    else                  fifo_q[1] <= push_data;
                    if (fifo_cnt != 2'd2) fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_q[0] <= push_data;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Credit count: lasts accepted minus results popped. It bounds the FIFO fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 2'd0;
        end else begin
            case ({accept & IN_LAST, pop})
                2'b10:   pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Bench for dsp48a1_mac_seq. It contains a behavioural DSP48A1 slice model
// (A/B reg 1, MREG 1, OPMODEREG 1, CREG 1, PREG 1). Results are checked
// against a queue of expected {P, carry} values.
module tb_dsp48a1_mac_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [17:0] IN_A;
    logic [17:0] IN_B;
    logic        IN_FIRST;
    logic        IN_LAST;
    logic [47:0] IN_BIAS;
    logic        IN_SUB;
    logic [17:0] DSP_A;
    logic [17:0] DSP_B;
    logic [17:0] DSP_D;
    logic [47:0] DSP_C;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CE;
    logic        DSP_CARRYIN;
    logic        DSP_RST;
    logic [47:0] DSP_P;
    logic        DSP_CARRYOUT;
    logic        RES_VALID;
    logic        RES_READY;
    logic [47:0] RES_DATA;
    logic        RES_CARRY;

    int tests = 0;
    int fails = 0;
    logic [48:0] exp_q[$];

    dsp48a1_mac_seq dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_A(IN_A), .IN_B(IN_B), .IN_FIRST(IN_FIRST), .IN_LAST(IN_LAST),
        .IN_BIAS(IN_BIAS), .IN_SUB(IN_SUB),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C),
        .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_CARRYIN(DSP_CARRYIN),
        .DSP_RST(DSP_RST), .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- slice model ----------------
    logic [17:0] s_a, s_b;
    logic [35:0] s_m;
    logic [7:0]  s_op;
    logic [47:0] s_c;
    logic [48:0] s_x, s_z, s_sum;

    always_comb begin
        s_x = (s_op[1:0] == 2'b01) ? {13'd0, s_m} : 49'd0;
        case (s_op[3:2])
            2'b11:   s_z = {1'b0, s_c};
            2'b10:   s_z = {1'b0, DSP_P};
            default: s_z = 49'd0;
        endcase
        s_sum = s_op[7] ? (s_z - s_x) : (s_z + s_x);
    end

    always @(posedge CLK) begin
        if (DSP_RST) begin
            s_a <= '0; s_b <= '0; s_m <= '0; s_op <= '0; s_c <= '0;
            DSP_P <= '0; DSP_CARRYOUT <= 1'b0;
        end else if (DSP_CE) begin
            s_a  <= DSP_A;
            s_b  <= DSP_B;
            s_m  <= 36'(s_a) * 36'(s_b);
            s_op <= DSP_OPMODE;
            s_c  <= DSP_C;
            DSP_P        <= s_sum[47:0];
            DSP_CARRYOUT <= s_sum[48] ^ DSP_CARRYIN;
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (!RST && RES_VALID) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h_%b expected none", RES_DATA, RES_CARRY);
            end else if (RES_READY) begin
                check("result", {15'd0, RES_DATA, RES_CARRY}, {15'd0, exp_q.pop_front()});
            end else begin
                check("hold", {15'd0, RES_DATA, RES_CARRY}, {15'd0, exp_q[0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic f,
                             input logic l, input logic [47:0] bias, input logic s);
        int g;
        @(negedge CLK);
        IN_A = a; IN_B = b; IN_FIRST = f; IN_LAST = l; IN_BIAS = bias; IN_SUB = s;
        IN_VALID = 1'b1;
        g = 0;
        while (!IN_READY && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (!IN_READY) begin
            check("accept_timeout", 64'(IN_READY), 64'd1);
            IN_VALID = 1'b0;
        end else begin
            @(posedge CLK);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            @(posedge CLK);
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge CLK);
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    typedef struct {
        int              n;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [47:0]     bias;
        logic            sub;
        logic [47:0]     exp_d;
        logic            exp_c;
    } vec_t;

    vec_t tbl[8];

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++)
            send_beat(v.a[i], v.b[i], (i == 0), (i == v.n - 1), v.bias, v.sub);
        exp_q.push_back({v.exp_d, v.exp_c});
    endtask

    task automatic set_vec(input int idx, input int n, input logic [3:0][17:0] a,
                           input logic [3:0][17:0] b, input logic [47:0] bias,
                           input logic sub, input logic [47:0] ed, input logic ec);
        tbl[idx].n = n; tbl[idx].a = a; tbl[idx].b = b; tbl[idx].bias = bias;
        tbl[idx].sub = sub; tbl[idx].exp_d = ed; tbl[idx].exp_c = ec;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int seen;
        RST = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_FIRST = 1'b0;
        IN_LAST = 1'b0; IN_BIAS = '0; IN_SUB = 1'b0; RES_READY = 1'b1;

        // Beats listed last-first inside the packed arrays: index 0 is the low slice.
        set_vec(0, 3, {18'd0, 18'd7, 18'd5, 18'd3}, {18'd0, 18'd8, 18'd6, 18'd4},
                48'd10, 1'b0, 48'd108, 1'b0);
        set_vec(1, 1, {54'd0, 18'h20000}, {54'd0, 18'h20000},
                48'd0, 1'b0, 48'h0004_0000_0000, 1'b0);
        set_vec(2, 1, {54'd0, 18'd1}, {54'd0, 18'd1}, 48'd5, 1'b1, 48'd4, 1'b0);
        set_vec(3, 1, {54'd0, 18'd1}, {54'd0, 18'd1},
                48'hFFFF_FFFF_FFFF, 1'b0, 48'd0, 1'b1);
        set_vec(4, 2, {36'd0, 18'd3, 18'd10}, {36'd0, 18'd3, 18'd10},
                48'd200, 1'b1, 48'd91, 1'b0);
        set_vec(5, 2, {36'd0, 18'h3FFFF, 18'h3FFFF}, {36'd0, 18'h3FFFF, 18'h3FFFF},
                48'd0, 1'b0, 48'h001F_FFF0_0002, 1'b0);
        set_vec(6, 2, {36'd0, 18'd1, 18'd4}, {36'd0, 18'd1, 18'd4},
                48'hFFFF_FFFF_FFF0, 1'b0, 48'd1, 1'b1);
        set_vec(7, 1, {54'd0, 18'd9}, {54'd0, 18'd9}, 48'd0, 1'b0, 48'd81, 1'b0);

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_res_valid", 64'(RES_VALID), 64'd0);
        check("rst_res_data", 64'(RES_DATA), 64'd0);
        check("rst_res_carry", 64'(RES_CARRY), 64'd0);
        check("rst_dsp_a", 64'(DSP_A), 64'd0);
        check("rst_dsp_b", 64'(DSP_B), 64'd0);
        check("rst_dsp_c", 64'(DSP_C), 64'd0);
        check("rst_dsp_opmode", 64'(DSP_OPMODE), 64'd0);
        check("rst_dsp_rst", 64'(DSP_RST), 64'd1);
        check("const_dsp_d", 64'(DSP_D), 64'd0);
        check("const_ce_cin", {62'd0, DSP_CE, DSP_CARRYIN}, 64'd2);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 64'(IN_READY), 64'd1);
        check("dsp_rst_low", 64'(DSP_RST), 64'd0);

        // Latency: result appears exactly 5 cycles after the last accept.
        run_vec(tbl[0]);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (k == 1) IN_VALID = 1'b0;
            check("latency", 64'(RES_VALID), (k == 5) ? 64'd1 : 64'd0);
        end
        wait_drain();

        // Table vectors back to back.
        for (int i = 1; i < 7; i++) run_vec(tbl[i]);
        idle();
        wait_drain();

        // Two 1-beat vectors back to back: results on consecutive cycles.
        run_vec(tbl[1]);
        run_vec(tbl[2]);
        @(negedge CLK);
        IN_VALID = 1'b0;
        cnt = 0;
        while (!RES_VALID && cnt < 20) begin
            @(negedge CLK);
            cnt++;
        end
        @(negedge CLK);
        check("pair_no_gap", 64'(RES_VALID), 64'd1);
        wait_drain();

        // Back-pressure: two results fill the credits and hold IN_READY low.
        @(negedge CLK);
        RES_READY = 1'b0;
        send_beat(18'd1, 18'd2, 1'b1, 1'b1, 48'd0, 1'b0);
        exp_q.push_back({48'd2, 1'b0});
        send_beat(18'd3, 18'd3, 1'b1, 1'b1, 48'd0, 1'b0);
        exp_q.push_back({48'd9, 1'b0});
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("ready_drop", 64'(IN_READY), 64'd0);
        fork
            send_beat(18'd4, 18'd5, 1'b1, 1'b1, 48'd0, 1'b0);
            begin
                repeat (10) @(negedge CLK);
                check("ready_held", 64'(IN_READY), 64'd0);
                RES_READY = 1'b1;
            end
        join
        exp_q.push_back({48'd20, 1'b0});
        idle();
        wait_drain();

        // Bubbles of 1, 3 and 0 cycles inside one vector.
        send_beat(18'd2, 18'd3, 1'b1, 1'b0, 48'd0, 1'b0);
        bubble(1);
        send_beat(18'd2, 18'd3, 1'b0, 1'b0, 48'd0, 1'b0);
        bubble(3);
        send_beat(18'd2, 18'd3, 1'b0, 1'b0, 48'd0, 1'b0);
        send_beat(18'd2, 18'd3, 1'b0, 1'b1, 48'd0, 1'b0);
        exp_q.push_back({48'd24, 1'b0});
        idle();
        wait_drain();

        // Abort: a FIRST inside an open vector restarts accumulation.
        send_beat(18'd5, 18'd5, 1'b1, 1'b0, 48'd7, 1'b0);
        send_beat(18'd5, 18'd5, 1'b0, 1'b0, 48'd7, 1'b0);
        send_beat(18'd2, 18'd2, 1'b1, 1'b0, 48'd1, 1'b0);
        send_beat(18'd3, 18'd3, 1'b0, 1'b1, 48'd1, 1'b0);
        exp_q.push_back({48'd14, 1'b0});
        idle();
        wait_drain();

        // Reset 2 cycles after a last accept: the in-flight vector never appears.
        send_beat(18'd7, 18'd7, 1'b1, 1'b1, 48'd0, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        RST = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge CLK);
            if (RES_VALID) seen++;
        end
        check("no_result_after_rst", 64'(seen), 64'd0);
        run_vec(tbl[7]);
        idle();
        wait_drain();

        // Beats before any FIRST after reset continue from a zero bias.
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        send_beat(18'd2, 18'd2, 1'b0, 1'b0, 48'd0, 1'b0);
        bubble(2);
        send_beat(18'd3, 18'd3, 1'b0, 1'b1, 48'd0, 1'b0);
        exp_q.push_back({48'd13, 1'b0});
        idle();
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
